// File: rtl/rocc_accum_pkg.sv
// Shared definitions for the RoCC accumulator bank:
// function codes, memory FSM states and the response bundle.
package rocc_accum_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] F_WRITE    = 7'd0;
    localparam logic [6:0] F_READ     = 7'd1;
    localparam logic [6:0] F_ACCUM    = 7'd2;
    localparam logic [6:0] F_LOAD_ACC = 7'd3;
    localparam logic [6:0] F_CLEAR    = 7'd4;
    localparam logic [6:0] F_READ_OVF = 7'd5;

    localparam logic [4:0] M_XRD = 5'b00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } resp_t;

endpackage

// File: rtl/rocc_resp_fifo.sv
// Small response FIFO with valid/ready on both sides.
// A push is accepted while full if a pop happens on the same edge.
module rocc_resp_fifo
    import rocc_accum_pkg::*;
#(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign full      = (count == CNT_MAX);
    assign empty     = (count == '0);
    assign in_ready  = !full || out_ready;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rocc_accum_bank.sv
// RoCC accelerator holding a bank of indexed accumulators with sticky
// carry-out flags, plus a load-and-accumulate path through the D$ port.
module rocc_accum_bank
    import rocc_accum_pkg::*;
#(
    parameter int xLen             = 64,
    parameter int NUM_ACC          = 4,
    parameter int RESP_DEPTH       = 2,
    parameter int coreMaxAddrBits  = 40,
    parameter int dcacheReqTagBits = 9,
    parameter int MEM_TAG          = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rocc_cmd_valid,
    output logic                        rocc_cmd_ready,
    input  logic [6:0]                  rocc_cmd_bits_inst_funct,
    input  logic [4:0]                  rocc_cmd_bits_inst_rd,
    input  logic                        rocc_cmd_bits_inst_xd,
    input  logic [xLen-1:0]             rocc_cmd_bits_rs1,
    input  logic [xLen-1:0]             rocc_cmd_bits_rs2,
    output logic                        rocc_resp_valid,
    input  logic                        rocc_resp_ready,
    output logic [4:0]                  rocc_resp_bits_rd,
    output logic [xLen-1:0]             rocc_resp_bits_data,
    output logic                        rocc_mem_req_valid,
    input  logic                        rocc_mem_req_ready,
    output logic [coreMaxAddrBits-1:0]  rocc_mem_req_bits_addr,
    output logic [dcacheReqTagBits-1:0] rocc_mem_req_bits_tag,
    output logic [4:0]                  rocc_mem_req_bits_cmd,
    output logic [1:0]                  rocc_mem_req_bits_size,
    output logic                        rocc_mem_req_bits_signed,
    output logic                        rocc_mem_req_bits_phys,
    output logic [xLen-1:0]             rocc_mem_req_bits_data,
    output logic [xLen/8-1:0]           rocc_mem_req_bits_mask,
    input  logic                        rocc_mem_s2_nack,
    input  logic                        rocc_mem_resp_valid,
    input  logic [dcacheReqTagBits-1:0] rocc_mem_resp_bits_tag,
    input  logic [xLen-1:0]             rocc_mem_resp_bits_data,
    output logic                        rocc_busy,
    output logic                        rocc_interrupt,
    input  logic                        rocc_exception
);

    localparam int IDXW = $clog2(NUM_ACC);
    localparam int RW   = 5 + xLen;
    localparam logic [dcacheReqTagBits-1:0] TAG = dcacheReqTagBits'(MEM_TAG);

    state_t                     state;
    logic [xLen-1:0]            acc [NUM_ACC];
    logic [NUM_ACC-1:0]         ovf;
    logic [IDXW-1:0]            lidx;
    logic [coreMaxAddrBits-1:0] laddr;
    logic [4:0]                 lrd;
    logic                       lxd;

    logic [IDXW-1:0] idx;
    logic [xLen:0]   cmd_sum;
    logic [xLen:0]   mem_sum;
    logic [xLen-1:0] op_data;
    logic            accept;
    logic            mem_hit;
    logic            push_valid;
    logic [RW-1:0]   push_data;
    logic [RW-1:0]   pop_data;
    logic            push_ready;
    logic            fifo_full;
    logic            fifo_empty;

    assign idx     = rocc_cmd_bits_rs2[IDXW-1:0];
    assign cmd_sum = {1'b0, acc[idx]} + {1'b0, rocc_cmd_bits_rs1};
    assign mem_sum = {1'b0, acc[lidx]} + {1'b0, rocc_mem_resp_bits_data};

    // Gated by reset so the core never sees ready while the bank is cleared.
    assign rocc_cmd_ready = reset && (state == IDLE) && !fifo_full;
    assign accept  = rocc_cmd_valid && rocc_cmd_ready;
    assign mem_hit = (state == WAIT) && !rocc_exception && !rocc_mem_s2_nack
                   && rocc_mem_resp_valid && (rocc_mem_resp_bits_tag == TAG);

    always_comb begin
        op_data = '1;
        case (rocc_cmd_bits_inst_funct)
            F_WRITE:    op_data = rocc_cmd_bits_rs1;
            F_READ:     op_data = acc[idx];
            F_ACCUM:    op_data = cmd_sum[xLen-1:0];
            F_CLEAR:    op_data = '0;
            F_READ_OVF: op_data = {{(xLen-NUM_ACC){1'b0}}, ovf};
            default:    op_data = '1;
        endcase
    end

    always_comb begin
        push_valid = 1'b0;
        push_data  = {rocc_cmd_bits_inst_rd, op_data};
        if (mem_hit) begin
            push_valid = lxd;
            push_data  = {lrd, mem_sum[xLen-1:0]};
        end else if (accept && rocc_cmd_bits_inst_xd
                     && rocc_cmd_bits_inst_funct != F_LOAD_ACC) begin
            push_valid = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            ovf   <= '0;
            lidx  <= '0;
            laddr <= '0;
            lrd   <= '0;
            lxd   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        case (rocc_cmd_bits_inst_funct)
                            F_WRITE: begin
                                acc[idx] <= rocc_cmd_bits_rs1;
                                ovf[idx] <= 1'b0;
                            end
                            F_ACCUM: begin
                                acc[idx] <= cmd_sum[xLen-1:0];
                                ovf[idx] <= ovf[idx] | cmd_sum[xLen];
                            end
                            F_LOAD_ACC: begin
                                state <= REQ;
                                lidx  <= idx;
                                laddr <= rocc_cmd_bits_rs1[coreMaxAddrBits-1:0];
                                lrd   <= rocc_cmd_bits_inst_rd;
                                lxd   <= rocc_cmd_bits_inst_xd;
                            end
                            F_CLEAR: begin
                                for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
                                ovf <= '0;
                            end
                            F_READ_OVF: ovf <= '0;
                            default: ;
                        endcase
                    end
                end
                REQ: begin
                    if (rocc_exception) state <= IDLE;
                    else if (rocc_mem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (rocc_exception) begin
                        state <= IDLE;
                    end else if (rocc_mem_s2_nack) begin
                        state <= REQ;
                    end else if (mem_hit) begin
                        acc[lidx] <= mem_sum[xLen-1:0];
                        ovf[lidx] <= ovf[lidx] | mem_sum[xLen];
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rocc_resp_fifo #(
        .WIDTH (RW),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_ready  (push_ready),
        .in_data   (push_data),
        .out_valid (rocc_resp_valid),
        .out_ready (rocc_resp_ready),
        .out_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rocc_resp_bits_rd   = pop_data[RW-1:xLen];
    assign rocc_resp_bits_data = pop_data[xLen-1:0];

    assign rocc_mem_req_valid       = (state == REQ);
    assign rocc_mem_req_bits_addr   = laddr;
    assign rocc_mem_req_bits_tag    = TAG;
    assign rocc_mem_req_bits_cmd    = M_XRD;
    assign rocc_mem_req_bits_size   = 2'd3;
    assign rocc_mem_req_bits_signed = 1'b0;
    assign rocc_mem_req_bits_phys   = 1'b0;
    assign rocc_mem_req_bits_data   = '0;
    assign rocc_mem_req_bits_mask   = '0;

    assign rocc_busy      = (state != IDLE) || !fifo_empty || !push_ready;
    assign rocc_interrupt = 1'b0;

endmodule
